// File: rtl/vram_cmd_writer_pkg.sv
// Shared definitions for the VRAM command writer.
//   MODE_*        : command bytes that select the parser mode
//   parse_state_t : command parser state encoding
package vram_cmd_pkg;

  localparam logic [7:0] MODE_DATA = 8'h01;
  localparam logic [7:0] MODE_ADDR = 8'h02;
  localparam logic [7:0] MODE_FILL = 8'h03;

  typedef enum logic [3:0] {
    ST_MODE,
    ST_DATA,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_FILL_VAL,
    ST_FILL_CLO,
    ST_FILL_CHI,
    ST_FILL_RUN,
    ST_IGNORE
  } parse_state_t;

endpackage

// File: rtl/vram_cmd_writer_if.sv
// Byte-stream input and VRAM write request bus of the command writer.
//   in_valid/in_data/in_frame_end/in_ready : decoded byte stream with backpressure
//   wr_req/wr_addr/wr_data/wr_ack          : FWFT write queue head offered to the arbiter
// slave = the command writer, master = decoder/arbiter side.
interface vram_cmd_writer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_frame_end;
  logic              in_ready;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  modport master (
    output in_valid, in_data, in_frame_end, wr_ack,
    input  in_ready, wr_req, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_frame_end, wr_ack,
    output in_ready, wr_req, wr_addr, wr_data
  );
endinterface

// File: rtl/vram_cmd_writer_wr_fifo.sv
// Synchronous first-word-fall-through write queue.
//   clk, reset_n : clock, asynchronous active-low reset
//   push/push_data : write an entry on the edge (ignored when full)
//   pop/pop_data   : pop_data is the current head; pop removes it (ignored when empty)
//   full/empty     : status derived from pointer registers
module vram_wr_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      // Cleared so the head reads zero out of reset.
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr              <= wptr + PTR_ONE;
      end
      if (pop && !empty) rptr <= rptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/vram_cmd_writer.sv
// VRAM command writer: parses decoded command bytes (data, address, fill),
// keeps an auto-incrementing VRAM address and queues {addr,data} writes
// for the SDRAM arbiter, backpressuring the decoder when the queue is full.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : byte input and write request bus (slave side)
//   cur_addr     : current write pointer (status)
module vram_cmd_writer
  import vram_cmd_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  vram_cmd_writer_if.slave    bus,
  output logic [ADDR_W-1:0]   cur_addr
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  parse_state_t       state;
  logic [15:0]        cnt;
  logic [DATA_W-1:0]  fill_val;

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic [ADDR_W+DATA_W-1:0] push_data;
  logic [ADDR_W+DATA_W-1:0] head;
  logic                     accept;
  logic                     fill_go;

  assign bus.in_ready = !fifo_full && (state != ST_FILL_RUN);
  // A byte arriving together with the frame delimiter is discarded.
  assign accept  = bus.in_valid && bus.in_ready && !bus.in_frame_end;
  assign fill_go = (state == ST_FILL_RUN) && !fifo_full && !bus.in_frame_end;

  always_comb begin
    push      = 1'b0;
    push_data = {cur_addr, bus.in_data};
    if (state == ST_DATA && accept) begin
      push = 1'b1;
    end else if (fill_go) begin
      push      = 1'b1;
      push_data = {cur_addr, fill_val};
    end
  end

  vram_wr_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(push_data),
    .pop      (bus.wr_ack),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.wr_req = !fifo_empty;
  assign {bus.wr_addr, bus.wr_data} = head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_MODE;
      cur_addr <= '0;
      cnt      <= '0;
      fill_val <= '0;
    end else if (bus.in_frame_end) begin
      state <= ST_MODE;
    end else begin
      case (state)
        ST_MODE: if (accept) begin
          case (bus.in_data)
            MODE_DATA: state <= ST_DATA;
            MODE_ADDR: state <= ST_ADDR_LO;
            MODE_FILL: state <= ST_FILL_VAL;
            default:   state <= ST_IGNORE;
          endcase
        end
        ST_DATA: if (accept) cur_addr <= cur_addr + ADDR_ONE;
        ST_ADDR_LO: if (accept) begin
          cur_addr[7:0] <= bus.in_data;
          state         <= ST_ADDR_HI;
        end
        ST_ADDR_HI: if (accept) begin
          cur_addr[15:8] <= bus.in_data;
          state          <= ST_MODE;
        end
        ST_FILL_VAL: if (accept) begin
          fill_val <= bus.in_data;
          state    <= ST_FILL_CLO;
        end
        ST_FILL_CLO: if (accept) begin
          cnt[7:0] <= bus.in_data;
          state    <= ST_FILL_CHI;
        end
        ST_FILL_CHI: if (accept) begin
          cnt[15:8] <= bus.in_data;
          state     <= ({bus.in_data, cnt[7:0]} == 16'h0000) ? ST_MODE : ST_FILL_RUN;
        end
        ST_FILL_RUN: if (fill_go) begin
          cur_addr <= cur_addr + ADDR_ONE;
          cnt      <= cnt - 16'd1;
          if (cnt == 16'd1) state <= ST_MODE;
        end
        ST_IGNORE: state <= ST_IGNORE;
        default:   state <= ST_MODE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_cmd_writer.sv
// Scoreboard bench for vram_cmd_writer: stimulus pushes expected writes,
// a negedge monitor pops and compares each acknowledged write.
module tb_vram_cmd_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cur_addr;

  vram_cmd_writer_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  vram_cmd_writer #(.ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .cur_addr(cur_addr)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [23:0] exp_q[$];
  logic [15:0] model_addr = 16'h0000;
  // 0: no ack, 1: ack whenever requested, 2: ack at slot 8 of each 16 cycles
  int unsigned ack_mode = 1;
  int unsigned slot = 0;
  bit          lazy_on = 1'b0;
  logic [15:0] lazy_addr = 16'h0000;
  int unsigned lazy_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Arbiter model
  initial begin
    bus.wr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      slot = (slot + 1) % 16;
      case (ack_mode)
        1:       bus.wr_ack = bus.wr_req;
        2:       bus.wr_ack = bus.wr_req && (slot == 8);
        default: bus.wr_ack = 1'b0;
      endcase
    end
  end

  // Monitor: a write is consumed on the edge following a negedge with req && ack
  always @(negedge clk) begin
    if (reset_n) begin
      assert (!(bus.wr_ack && !bus.wr_req)) else $error("wr_ack while queue empty");
      if (bus.wr_req && bus.wr_ack) begin
        if (lazy_on) begin
          check("fill_write", {bus.wr_addr, bus.wr_data}, {8'h00, lazy_addr, 8'h5A});
          lazy_addr = lazy_addr + 16'd1;
          lazy_cnt++;
        end else if (exp_q.size() == 0) begin
          check("unexpected_write", {bus.wr_addr, bus.wr_data}, 32'hFFFF_FFFF);
        end else begin
          check("write", {bus.wr_addr, bus.wr_data}, {8'h00, exp_q.pop_front()});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted, in_ready %b expected 1", b, bus.in_ready);
    end
  endtask

  task automatic frame_end();
    bus.in_frame_end = 1'b1;
    @(posedge clk);
    #1;
    bus.in_frame_end = 1'b0;
  endtask

  task automatic data_byte(input logic [7:0] b);
    exp_q.push_back({model_addr, b});
    model_addr = model_addr + 16'd1;
    send_byte(b);
  endtask

  task automatic set_addr(input logic [15:0] a);
    send_byte(8'h02);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    frame_end();
    model_addr = a;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || bus.wr_req) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.wr_req) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d writes outstanding expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_data      = 8'h00;
    bus.in_frame_end = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_wr_req", bus.wr_req, 0);
    check("reset_wr_head", {bus.wr_addr, bus.wr_data}, 0);
    check("reset_cur_addr", cur_addr, 0);

    // 1: basic data frame
    ack_mode = 1;
    send_byte(8'h01);
    data_byte(8'hAA);
    data_byte(8'hBB);
    data_byte(8'hCC);
    frame_end();
    wait_idle("t1_idle");
    check("t1_cur_addr", cur_addr, 16'h0003);

    // 2: address then data
    set_addr(16'h1234);
    send_byte(8'h01);
    data_byte(8'h55);
    frame_end();
    wait_idle("t2_idle");
    check("t2_cur_addr", cur_addr, 16'h1235);

    // 3: address wrap
    set_addr(16'hFFFF);
    send_byte(8'h01);
    data_byte(8'h11);
    data_byte(8'h22);
    frame_end();
    wait_idle("t3_idle");
    check("t3_cur_addr", cur_addr, 16'h0001);

    // 4: backpressure with no ack, then slotted acks
    set_addr(16'h2000);
    ack_mode = 0;
    send_byte(8'h01);
    data_byte(8'h61);
    data_byte(8'h62);
    data_byte(8'h63);
    data_byte(8'h64);
    check("t4_full_in_ready", bus.in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_still_blocked", bus.in_ready, 0);
    check("t4_head", {bus.wr_req, bus.wr_addr, bus.wr_data}, {1'b1, 16'h2000, 8'h61});
    ack_mode = 2;
    data_byte(8'h65);
    data_byte(8'h66);
    frame_end();
    wait_idle("t4_idle");
    check("t4_cur_addr", cur_addr, 16'h2006);

    // 5: fill of 5, then zero-length fill
    ack_mode = 1;
    set_addr(16'h0100);
    for (int unsigned i = 0; i < 5; i++) exp_q.push_back({16'h0100 + 16'(i), 8'h7E});
    model_addr = 16'h0105;
    send_byte(8'h03);
    send_byte(8'h7E);
    send_byte(8'h05);
    send_byte(8'h00);
    check("t5_fill_in_ready", bus.in_ready, 0);
    wait_idle("t5_idle");
    check("t5_cur_addr", cur_addr, 16'h0105);
    send_byte(8'h03);
    send_byte(8'h7E);
    send_byte(8'h00);
    send_byte(8'h00);
    check("t5_zero_in_ready", bus.in_ready, 1);
    frame_end();
    wait_idle("t5_zero_idle");
    check("t5_zero_cur_addr", cur_addr, 16'h0105);

    // 6: long fill cut short by frame end, then an unknown mode
    set_addr(16'h0200);
    lazy_addr = 16'h0200;
    lazy_cnt  = 0;
    lazy_on   = 1'b1;
    send_byte(8'h03);
    send_byte(8'h5A);
    send_byte(8'h00);
    send_byte(8'h01);
    repeat (10) @(posedge clk);
    #1;
    frame_end();
    wait_idle("t6_idle");
    lazy_on = 1'b0;
    check("t6_fill_writes", lazy_cnt, 10);
    check("t6_cur_addr", cur_addr, 16'h0200 + 16'(lazy_cnt));
    model_addr = 16'h0200 + 16'(lazy_cnt);
    send_byte(8'h09);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    frame_end();
    wait_idle("t6_ignore_idle");
    check("t6_ignore_cur_addr", cur_addr, model_addr);
    send_byte(8'h01);
    data_byte(8'h77);
    frame_end();
    wait_idle("t6_mode_idle");
    check("t6_mode_cur_addr", cur_addr, model_addr);

    // Reset in the middle of a frame with queued writes
    ack_mode = 0;
    send_byte(8'h01);
    send_byte(8'h33);
    send_byte(8'h44);
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_reset_wr_req", bus.wr_req, 0);
    check("mid_reset_cur_addr", cur_addr, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset_in_ready", bus.in_ready, 1);
    check("mid_reset_head", {bus.wr_addr, bus.wr_data}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
